msp430_prog_loader: RTL and testbench
=====================================

Name: msp430_prog_loader

Overview:
Program-image loader that drives the core's Load_en input and fills instruction memory. It receives a framed byte stream over a valid/ready handshake and assembles little-endian 16-bit words. Each word is written to consecutive memory addresses starting at 0, and the frame is checked with an XOR checksum. Load_en is held high for the whole load, so the core stays in load mode until the image is complete.

Parameters:
ADDR_W, 10, instruction-memory word-address width (matches 10-bit PC offset path)
START_BYTE, 8'hA5, frame start marker
TIMEOUT_CYC, 1000, inter-byte timeout in Clk cycles (used only with LOADER_TIMEOUT_EN)

Ports:
Clk  input  1  system clock, all logic on rising edge
Rst  input  1  synchronous reset, active-low (Rst==0 at rising Clk resets)
Byte_data  input  8  incoming stream byte
Byte_valid  input  1  Byte_data valid
Byte_ready  output  1  loader can accept a byte; transfer = Byte_valid & Byte_ready at rising Clk
Load_en  output  1  to core Load_en; high while a frame is in progress
Mem_wr_en  output  1  one-cycle instruction-memory write strobe
Mem_addr  output  ADDR_W  word address of write
Mem_data  output  16  write data {hi,lo}
Word_cnt  output  8  words written in current/last frame
Done  output  1  sticky: last frame completed with good checksum
Err  output  1  sticky: last frame failed (checksum, or timeout if enabled)

Behaviour:
- Reset (Rst==0) has priority over everything:
  - state IDLE, all outputs 0; chk, count and addr cleared.
  - No Mem_wr_en in the reset cycle, even mid-frame.
- Byte_ready=1 in IDLE, LEN, LO, HI, CHK; 0 in WRITE and in the reset cycle.
- IDLE:
  - Byte == START_BYTE -> LEN. Load_en=1 next cycle; Done, Err, Word_cnt cleared; chk=0; addr=0.
  - Any other byte is discarded; stay in IDLE.
- LEN: accepted byte N = word count.
  - N==0 -> CHK.
  - Otherwise remaining=N -> LO.
- LO: lo=byte, chk^=byte -> HI.
- HI: hi=byte, chk^=byte -> WRITE.
- WRITE (exactly 1 cycle):
  - Mem_wr_en=1, Mem_addr=addr, Mem_data={hi,lo}.
  - Next cycle: addr+=1 (wraps mod 2^ADDR_W), Word_cnt+=1, remaining-=1.
  - remaining becomes 0 -> CHK, else -> LO.
- CHK: accepted byte compared to chk.
  - Equal -> Done=1.
  - Not equal -> Err=1.
  - Either way: Load_en=0 next cycle, state IDLE.
- Write latency: Mem_wr_en asserts the cycle after the high byte is accepted.
- Minimum frame duration is 2 + 3N + 1 cycles at full Byte_valid rate.
- Byte_valid while Byte_ready=0: byte not consumed; source must hold it.
- Writes already issued are not rolled back on checksum failure.
- Mem_addr/Mem_data hold their last values when Mem_wr_en=0.
- START_BYTE value inside a frame is ordinary data; frames cannot be aborted in-band.

Optional Feature:
LOADER_TIMEOUT_EN:
- Defined:
  - In LEN/LO/HI/CHK, a counter increments every cycle with no accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT_CYC -> Err=1, Load_en=0, state IDLE next cycle; no partial write issued.
- Undefined: no counter; the loader waits indefinitely for bytes.

Test Plan:
- Stream A5,02,34,12,78,56,08 -> writes addr0=0x1234, addr1=0x5678; Word_cnt=2; Done=1, Err=0; Load_en high from cycle after A5 through CHK, low after.
- Same stream with checksum 09 -> both writes occur, Err=1, Done=0, Load_en drops after checksum byte.
- Leading junk 00,FF,5A then valid frame -> junk ignored, Load_en stays 0 until A5, frame loads normally.
- A5,00,00 -> no Mem_wr_en, Word_cnt=0, Done=1; then a second good frame clears Done at its A5 and rewrites from addr 0.
- Reset pulse (Rst=0 one cycle) right after low byte of word 0 -> no write, Load_en=0, IDLE; Byte_valid held high during WRITE is not consumed (Byte_ready=0).
- With LOADER_TIMEOUT_EN, stall 1000 cycles after A5,01,34 -> Err=1, Load_en=0, no write; without the macro, the same stall keeps Load_en=1.

Source files
------------

// File: rtl/msp430_prog_loader.sv
// Framed byte-stream program loader: fills instruction memory and holds Load_en.
// Optional inter-byte timeout is enabled with `define LOADER_TIMEOUT_EN.
module msp430_prog_loader #(
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] START_BYTE  = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        Byte_data,
  input  logic              Byte_valid,
  output logic              Byte_ready,
  output logic              Load_en,
  output logic              Mem_wr_en,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [15:0]       Mem_data,
  output logic [7:0]        Word_cnt,
  output logic              Done,
  output logic              Err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_LO, S_HI, S_WRITE, S_CHK
  } state_t;

  state_t            state, state_n;
  logic [7:0]        chk;
  logic [7:0]        remaining;
  logic [7:0]        lo;
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic              acc;
  logic              tmo;

  assign Byte_ready = Rst && (state != S_WRITE);
  assign acc        = Byte_valid && Byte_ready;
  assign Mem_wr_en  = wr && Rst;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic          waiting;

  assign waiting = (state inside {S_LEN, S_LO, S_HI, S_CHK}) && !acc;
  assign tmo     = waiting && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clk) begin
    if (!Rst)
      idle_cnt <= '0;
    else if (waiting && !tmo)
      idle_cnt <= idle_cnt + 1'b1;
    else
      idle_cnt <= '0;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (acc && Byte_data == START_BYTE) state_n = S_LEN;
      S_LEN:   if (acc) state_n = (Byte_data == 8'd0) ? S_CHK : S_LO;
      S_LO:    if (acc) state_n = S_HI;
      S_HI:    if (acc) state_n = S_WRITE;
      S_WRITE: state_n = (remaining == 8'd1) ? S_CHK : S_LO;
      S_CHK:   if (acc) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (tmo) state_n = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= S_IDLE;
      chk       <= '0;
      remaining <= '0;
      lo        <= '0;
      addr      <= '0;
      wr        <= 1'b0;
      Load_en   <= 1'b0;
      Mem_addr  <= '0;
      Mem_data  <= '0;
      Word_cnt  <= '0;
      Done      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state <= state_n;
      wr    <= 1'b0;
      unique case (state)
        S_IDLE: if (acc && Byte_data == START_BYTE) begin
          Load_en  <= 1'b1;
          Done     <= 1'b0;
          Err      <= 1'b0;
          Word_cnt <= '0;
          chk      <= '0;
          addr     <= '0;
        end
        S_LEN: if (acc) remaining <= Byte_data;
        S_LO: if (acc) begin
          lo  <= Byte_data;
          chk <= chk ^ Byte_data;
        end
        S_HI: if (acc) begin
          chk      <= chk ^ Byte_data;
          Mem_addr <= addr;
          Mem_data <= {Byte_data, lo};
          wr       <= 1'b1;
        end
        S_WRITE: begin
          addr      <= addr + 1'b1;
          Word_cnt  <= Word_cnt + 1'b1;
          remaining <= remaining - 1'b1;
        end
        S_CHK: if (acc) begin
          Load_en <= 1'b0;
          Done    <= (Byte_data == chk);
          Err     <= (Byte_data != chk);
        end
        default: ;
      endcase
      if (tmo) begin
        Err     <= 1'b1;
        Load_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msp430_prog_loader.sv
// Bench for msp430_prog_loader: vector table, corner sequences, random frames.
module tb_msp430_prog_loader;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [7:0] Byte_data = 8'h00;
  logic       Byte_valid = 1'b0;
  logic       Byte_ready;
  logic       Load_en;
  logic       Mem_wr_en;
  logic [9:0] Mem_addr;
  logic [15:0] Mem_data;
  logic [7:0] Word_cnt;
  logic       Done;
  logic       Err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [25:0] wlog[$];

  msp430_prog_loader dut (
    .Clk(Clk), .Rst(Rst),
    .Byte_data(Byte_data), .Byte_valid(Byte_valid), .Byte_ready(Byte_ready),
    .Load_en(Load_en), .Mem_wr_en(Mem_wr_en), .Mem_addr(Mem_addr),
    .Mem_data(Mem_data), .Word_cnt(Word_cnt), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk)
    if (Mem_wr_en) wlog.push_back({Mem_addr, Mem_data});

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    Byte_data = b;
    Byte_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge Clk);
      if (Byte_ready) break;
      k++;
      if (k > 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: byte %0h not accepted", b);
        break;
      end
    end
    @(posedge Clk);
    #1;
    Byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  typedef struct packed {
    logic [79:0] s;
    int          nb;
    int          cnt;
    logic        done;
    logic        err;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0] fr[$];
    logic [15:0] words[$];
    logic [7:0] c;
    logic [7:0] b;
    int n;
    bit good;

    tbl[0] = '{80'hA5023412785608, 7, 2, 1'b1, 1'b0, 16'h1234, 16'h5678};
    tbl[1] = '{80'hA5023412785609, 7, 2, 1'b0, 1'b1, 16'h1234, 16'h5678};
    tbl[2] = '{80'h00FF5AA5023412785608, 10, 2, 1'b1, 1'b0, 16'h1234, 16'h5678};
    tbl[3] = '{80'hA50000, 3, 0, 1'b1, 1'b0, 16'h0, 16'h0};
    tbl[4] = '{80'hA501A5A500, 5, 1, 1'b1, 1'b0, 16'hA5A5, 16'h0};

    @(posedge Clk);
    #1;
    check("rst_ready", {31'b0, Byte_ready}, 0);
    check("rst_load", {31'b0, Load_en}, 0);
    check("rst_wr", {31'b0, Mem_wr_en}, 0);
    check("rst_cnt", {24'b0, Word_cnt}, 0);
    check("rst_flags", {30'b0, Done, Err}, 0);
    idle(2);
    Rst = 1'b1;
    idle(1);
    check("idle_ready", {31'b0, Byte_ready}, 1);

    send(8'h00);
    send(8'h5A);
    check("junk_load", {31'b0, Load_en}, 0);
    send(8'hA5);
    check("a5_load", {31'b0, Load_en}, 1);
    send(8'h00);
    send(8'h00);
    check("empty_load", {31'b0, Load_en}, 0);
    check("empty_done", {31'b0, Done}, 1);
    idle(2);

    foreach (tbl[i]) begin
      wlog.delete();
      for (int k = 0; k < tbl[i].nb; k++)
        send(8'(tbl[i].s >> (8 * (tbl[i].nb - 1 - k))));
      idle(2);
      check($sformatf("v%0d_cnt", i), {24'b0, Word_cnt}, tbl[i].cnt);
      check($sformatf("v%0d_done", i), {31'b0, Done}, {31'b0, tbl[i].done});
      check($sformatf("v%0d_err", i), {31'b0, Err}, {31'b0, tbl[i].err});
      check($sformatf("v%0d_load", i), {31'b0, Load_en}, 0);
      check($sformatf("v%0d_nwr", i), wlog.size(), tbl[i].cnt);
      if (tbl[i].cnt >= 1 && wlog.size() >= 1)
        check($sformatf("v%0d_w0", i), {6'b0, wlog[0]}, {16'b0, tbl[i].w0});
      if (tbl[i].cnt >= 2 && wlog.size() >= 2)
        check($sformatf("v%0d_w1", i), {6'b0, wlog[1]}, {16'h1, tbl[i].w1});
    end

    // second frame clears Done at its start byte and rewrites address 0
    send(8'hA5);
    check("f2_done_clr", {31'b0, Done}, 0);
    check("f2_cnt_clr", {24'b0, Word_cnt}, 0);
    send(8'h01);
    send(8'h34);
    Byte_data = 8'h12;
    Byte_valid = 1'b1;
    @(posedge Clk);
    #1;
    Byte_data = 8'h26;
    check("lat_wr", {31'b0, Mem_wr_en}, 1);
    check("lat_ready", {31'b0, Byte_ready}, 0);
    check("lat_addr", {22'b0, Mem_addr}, 0);
    check("lat_data", {16'b0, Mem_data}, 32'h1234);
    @(posedge Clk);
    #1;
    check("hold_wr", {31'b0, Mem_wr_en}, 0);
    check("hold_data", {16'b0, Mem_data}, 32'h1234);
    @(posedge Clk);
    #1;
    Byte_valid = 1'b0;
    check("held_done", {31'b0, Done}, 1);
    check("held_load", {31'b0, Load_en}, 0);

    // reset after the low byte of word 0
    wlog.delete();
    send(8'hA5);
    send(8'h01);
    send(8'h34);
    Rst = 1'b0;
    Byte_data = 8'h12;
    Byte_valid = 1'b1;
    #2;
    check("rstmid_ready", {31'b0, Byte_ready}, 0);
    @(posedge Clk);
    #1;
    check("rstmid_load", {31'b0, Load_en}, 0);
    check("rstmid_wr", {31'b0, Mem_wr_en}, 0);
    Rst = 1'b1;
    Byte_valid = 1'b0;
    idle(3);
    check("rstmid_nwr", wlog.size(), 0);
    check("rstmid_flags", {30'b0, Done, Err}, 0);

    // stall inside a frame
    send(8'hA5);
    send(8'h01);
    send(8'h34);
    idle(1005);
`ifdef LOADER_TIMEOUT_EN
    check("tmo_err", {31'b0, Err}, 1);
    check("tmo_load", {31'b0, Load_en}, 0);
    check("tmo_nwr", wlog.size(), 0);
`else
    check("stall_load", {31'b0, Load_en}, 1);
    check("stall_err", {31'b0, Err}, 0);
    send(8'h12);
    send(8'h26);
    idle(1);
    check("stall_done", {31'b0, Done}, 1);
`endif
    idle(2);

    // random frames against a frame-level reference
    for (int f = 0; f < 30; f++) begin
      fr.delete();
      words.delete();
      wlog.delete();
      n = $urandom_range(0, 6);
      good = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h3C;
        fr.push_back(b);
      end
      fr.push_back(8'hA5);
      fr.push_back(8'(n));
      c = 8'h00;
      for (int w = 0; w < n; w++) begin
        words.push_back(16'($urandom));
        fr.push_back(words[w][7:0]);
        fr.push_back(words[w][15:8]);
        c = c ^ words[w][7:0] ^ words[w][15:8];
      end
      fr.push_back(good ? c : c ^ 8'($urandom_range(1, 255)));
      foreach (fr[k]) begin
        send(fr[k]);
        idle($urandom_range(0, 2));
      end
      idle(2);
      check($sformatf("r%0d_cnt", f), {24'b0, Word_cnt}, n);
      check($sformatf("r%0d_done", f), {31'b0, Done}, {31'b0, good});
      check($sformatf("r%0d_err", f), {31'b0, Err}, {31'b0, !good});
      check($sformatf("r%0d_load", f), {31'b0, Load_en}, 0);
      check($sformatf("r%0d_nwr", f), wlog.size(), n);
      for (int w = 0; w < n && w < wlog.size(); w++)
        check($sformatf("r%0d_w%0d", f, w), {6'b0, wlog[w]},
              {6'b0, 10'(w), words[w]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
